// File: rtl/instr_encoder.sv
// instr_encoder: packs structured RV32I operation requests into 32-bit
// instruction words, tags each word with a sequential byte address and
// buffers the results in a small in-order FIFO for the instruction-memory
// write port.
//
// Handshake rule (both ports): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holds valid and its
// payload steady until that edge. req_ready comes only from registered
// occupancy, so it has no combinational path from out_ready.
module instr_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [2:0]                    req_kind,
    input  logic [2:0]                    req_funct3,
    input  logic                          req_alt,
    input  logic [4:0]                    req_rd,
    input  logic [4:0]                    req_rs1,
    input  logic [4:0]                    req_rs2,
    input  logic [20:0]                   req_imm,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_instr,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    output logic                          err_illegal,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Request classes as carried on req_kind
    localparam logic [2:0] KIND_R      = 3'd0;
    localparam logic [2:0] KIND_I      = 3'd1;
    localparam logic [2:0] KIND_LOAD   = 3'd2;
    localparam logic [2:0] KIND_STORE  = 3'd3;
    localparam logic [2:0] KIND_BRANCH = 3'd4;
    localparam logic [2:0] KIND_JAL    = 3'd5;

    // Major opcodes, identical to the control_unit decode map
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

    // Storage and bookkeeping
    logic [31:0]           r_instr_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_addr_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_addr_cnt;
    logic                  r_err;

    logic [31:0]           w_instr;
    logic                  w_illegal;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_not_empty;
    logic                  w_not_full;
    logic [6:0]            w_funct7;
    logic                  w_is_shift;

    assign w_not_empty = (r_count != '0);
    assign w_not_full  = (r_count < CNT_W'(FIFO_DEPTH));

    // A rejected request still completes its handshake but never lands
    // in the FIFO, so the address counter only moves on real pushes.
    assign w_accept = req_valid && w_not_full;
    assign w_push   = w_accept && !w_illegal;
    assign w_pop    = w_not_empty && out_ready;

    // Shift-immediate forms carry funct7 in [31:25]; alt only means SRAI
    assign w_is_shift = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
    assign w_funct7   = req_alt ? FUNCT7_ALT : 7'b0000000;

    // Combinational encode of the presented request and legality check
    always_comb begin
        w_instr   = 32'h0;
        w_illegal = 1'b0;
        case (req_kind)
            KIND_R: begin
                w_instr = {w_funct7, req_rs2, req_rs1, req_funct3, req_rd, OP_R};
            end
            KIND_I: begin
                if (w_is_shift) begin
                    w_instr = {1'b0, (req_funct3 == 3'b101) && req_alt, 5'b00000,
                               req_imm[4:0], req_rs1, req_funct3, req_rd, OP_I};
                end else begin
                    w_instr = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_I};
                end
            end
            KIND_LOAD: begin
                w_instr = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD};
            end
            KIND_STORE: begin
                w_instr = {req_imm[11:5], req_rs2, req_rs1, req_funct3,
                           req_imm[4:0], OP_STORE};
            end
            KIND_BRANCH: begin
                // Branch targets are half-word aligned; an odd offset is rejected
                w_illegal = req_imm[0];
                w_instr   = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                             req_imm[4:1], req_imm[11], OP_BRANCH};
            end
            KIND_JAL: begin
                w_illegal = req_imm[0];
                w_instr   = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                             req_rd, OP_JAL};
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // FIFO payload write; contents need no reset because occupancy gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= w_instr;
            r_addr_mem[r_wr_ptr]  <= r_addr_cnt;
        end
    end

    // Pointers, occupancy, address counter and the rejection pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_addr_cnt <= BASE;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_accept && w_illegal;
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
                r_addr_cnt <= r_addr_cnt + STEP;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head presentation: zero word when empty, next address shown meanwhile
    always_comb begin
        out_instr = 32'h0;
        out_addr  = r_addr_cnt;
        if (w_not_empty) begin
            out_instr = r_instr_mem[r_rd_ptr];
            out_addr  = r_addr_mem[r_rd_ptr];
        end
    end

    assign out_valid   = w_not_empty;
    assign req_ready   = w_not_full;
    assign err_illegal = r_err;
    assign fifo_count  = r_count;

endmodule
